// File: rtl/fish_pkg.sv
// Shared types and constants for the fish sprite scheduler: screen size,
// LFSR taps, the sprite slot record and the table-walk FSM states.
package fish_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

    // One step of the right-shifting Galois LFSR
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/fish_lfsr16.sv
// Seeded 16-bit Galois LFSR; steps once per cycle while advance is high.
module fish_lfsr16
    import fish_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] value
);

    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/fish_sprite_scheduler.sv
// Fish sprite table for the ocean scene: walks the table once per frame
// (move left or respawn at the right edge with a pseudo-random row) and
// performs the registered per-pixel hit test with lowest-index priority.
// Optional build macro FISH_WOBBLE_EN: non-respawning slots also drift
// vertically by +/-1 per frame, clamped to the visible area.
module fish_sprite_scheduler #(
    parameter int unsigned N_FISH    = 4,
    parameter int unsigned SCREEN_W  = fish_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H  = fish_pkg::SCREEN_H,
    parameter int unsigned FISH_W    = 10,
    parameter int unsigned FISH_H    = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int unsigned IDX_W    = (N_FISH > 1) ? $clog2(N_FISH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic [1:0]       speed,
    input  logic             video_active,
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    output logic             fish_hit,
    output logic [IDX_W-1:0] fish_idx,
    output logic             busy,
    output logic             frame_done
);

    import fish_pkg::*;

    localparam int unsigned CMP_W = COORD_W + 1;

    localparam logic [COORD_W-1:0] RESPAWN_X = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] Y_LIMIT   = COORD_W'(SCREEN_H - FISH_H);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(SCREEN_H - FISH_H - 1);
    localparam logic [IDX_W-1:0]   LAST_SLOT = IDX_W'(N_FISH - 1);

    state_t             state;
    logic [IDX_W-1:0]   slot;
    slot_t              table_q [N_FISH];
    logic [15:0]        lfsr;
    logic               lfsr_adv_c;
    slot_t              cur_c;
    slot_t              next_c;
    logic [COORD_W-1:0] r_c;
    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;
    logic               unused_lfsr_hi_c;

    // Row source for respawns; advances once per slot visited
    fish_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .advance(lfsr_adv_c),
        .value  (lfsr)
    );

    assign lfsr_adv_c       = (state == UPDATE);
    assign unused_lfsr_hi_c = ^lfsr[15:9];

    // New value for the slot currently being visited
    always_comb begin
        cur_c  = table_q[slot];
        next_c = cur_c;
        r_c    = {1'b0, lfsr[8:0]};
        if (cur_c.x > COORD_W'(speed)) begin
            next_c.x = cur_c.x - COORD_W'(speed);
`ifdef FISH_WOBBLE_EN
            if (lfsr[0]) begin
                if (cur_c.y < Y_MAX) begin
                    next_c.y = cur_c.y + COORD_W'(1);
                end
            end else if (cur_c.y != '0) begin
                next_c.y = cur_c.y - COORD_W'(1);
            end
`endif
        end else begin
            next_c.x = RESPAWN_X;
            next_c.y = (r_c < Y_LIMIT) ? r_c : (r_c - COORD_W'(256));
        end
    end

    // Table-walk FSM, slot table and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < int'(N_FISH); i++) begin
                table_q[i].x <= COORD_W'(SCREEN_W - i * (SCREEN_W / N_FISH));
                table_q[i].y <= COORD_W'(40 + i * 64);
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick && enable) begin
                        state <= UPDATE;
                        slot  <= '0;
                        busy  <= 1'b1;
                    end
                end
                UPDATE: begin
                    table_q[slot] <= next_c;
                    if (slot == LAST_SLOT) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        slot <= slot + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-pixel hit test; scanning downwards leaves the lowest hitting index
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = int'(N_FISH) - 1; i >= 0; i--) begin
            if ((CMP_W'(pix_x) >= CMP_W'(table_q[i].x)) &&
                (CMP_W'(pix_x) <  CMP_W'(table_q[i].x) + CMP_W'(FISH_W)) &&
                (CMP_W'(pix_y) >= CMP_W'(table_q[i].y)) &&
                (CMP_W'(pix_y) <  CMP_W'(table_q[i].y) + CMP_W'(FISH_H))) begin
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end

    // Registered hit result, blanked outside active video
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fish_hit <= 1'b0;
            fish_idx <= '0;
        end else if (video_active) begin
            fish_hit <= hit_c;
            fish_idx <= idx_c;
        end else begin
            fish_hit <= 1'b0;
            fish_idx <= '0;
        end
    end

endmodule

// File: tb/tb_fish_sprite_scheduler.sv
// Bench for fish_sprite_scheduler: a default 4-slot instance plus a dense
// 8-slot, 16-pixel-wide instance where sprites overlap often. A frame-level
// model of both tables predicts every hit result cycle by cycle.
module tb_fish_sprite_scheduler;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       enable;
    logic [1:0] speed;
    logic       video_active;
    logic [9:0] pix_x;
    logic [9:0] pix_y;

    logic       hit_a, busy_a, done_a;
    logic [1:0] idx_a;
    logic       hit_b, busy_b, done_b;
    logic [2:0] idx_b;

    int n_checks = 0;
    int n_fail   = 0;
    int wrap_cnt = 0;
    int ovl_cnt  = 0;
    bit check_en = 0;

    int          mx    [2][8];
    int          my    [2][8];
    logic [15:0] mlfsr [2];

    fish_sprite_scheduler #(.N_FISH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .speed(speed), .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y),
        .fish_hit(hit_a), .fish_idx(idx_a), .busy(busy_a), .frame_done(done_a)
    );

    fish_sprite_scheduler #(.N_FISH(8), .SCREEN_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .speed(speed), .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y),
        .fish_hit(hit_b), .fish_idx(idx_b), .busy(busy_b), .frame_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nf(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic int sw(input int k);
        return (k == 0) ? 640 : 16;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic void model_reset(input int k);
        for (int i = 0; i < nf(k); i++) begin
            mx[k][i] = sw(k) - i * (sw(k) / nf(k));
            my[k][i] = 40 + i * 64;
        end
        mlfsr[k] = 16'hACE1;
    endfunction

    // One whole frame of table maintenance
    function automatic void model_frame(input int k, input int spd);
        for (int i = 0; i < nf(k); i++) begin
            int r;
            r = int'(mlfsr[k] & 16'h01FF);
            if (mx[k][i] > spd) begin
                mx[k][i] = mx[k][i] - spd;
`ifdef FISH_WOBBLE_EN
                if (mlfsr[k][0]) begin
                    if (my[k][i] < 474) my[k][i] = my[k][i] + 1;
                end else if (my[k][i] > 0) begin
                    my[k][i] = my[k][i] - 1;
                end
`endif
            end else begin
                mx[k][i] = sw(k);
                if (r < 475) begin
                    my[k][i] = r;
                end else begin
                    my[k][i] = r - 256;
                    wrap_cnt++;
                end
            end
            mlfsr[k] = lfsr_next(mlfsr[k]);
        end
    endfunction

    // First (lowest) slot whose rectangle contains the pixel
    task automatic model_hit(input int k, input int px, input int py, input bit va,
                             output int hit, output int idx);
        hit = 0;
        idx = 0;
        if (va) begin
            for (int i = 0; i < nf(k); i++) begin
                if (hit == 0 && px >= mx[k][i] && px < mx[k][i] + 10 &&
                    py >= my[k][i] && py < my[k][i] + 5) begin
                    hit = 1;
                    idx = i;
                end
            end
        end
    endtask

    // Cycle-by-cycle hit comparison for both instances
    initial begin
        int eh [2];
        int ei [2];
        bit chk;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                model_hit(k, int'(pix_x), int'(pix_y), video_active, eh[k], ei[k]);
            end
            chk = check_en;
            @(negedge clk);
            if (chk) begin
                check("a_hit", int'(hit_a), eh[0]);
                check("a_idx", int'(idx_a), ei[0]);
                check("b_hit", int'(hit_b), eh[1]);
                check("b_idx", int'(idx_b), ei[1]);
            end
        end
    end

    task automatic probe(input int x, input int y, input bit va);
        pix_x        = 10'(x);
        pix_y        = 10'(y);
        video_active = va;
        @(negedge clk);
    endtask

    // Corners and just-outside points of every slot of the 4-slot table
    task automatic probe_all_a();
        int dxs [6] = '{0, -1, 9, 10, 0, 9};
        int dys [6] = '{0, 0, 4, 4, -1, 5};
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 6; p++) begin
                probe(mx[0][s] + dxs[p], my[0][s] + dys[p], 1'b1);
            end
        end
        video_active = 1'b0;
    endtask

    // Probe the first overlapping pair in the dense table, if any
    task automatic probe_overlap_b();
        bit found;
        int x0, y0, lo;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                int ax, ay, bx, by;
                ax = (mx[1][i] > mx[1][j]) ? mx[1][i] : mx[1][j];
                ay = (my[1][i] > my[1][j]) ? my[1][i] : my[1][j];
                bx = ((mx[1][i] < mx[1][j]) ? mx[1][i] : mx[1][j]) + 10;
                by = ((my[1][i] < my[1][j]) ? my[1][i] : my[1][j]) + 5;
                if (!found && ax < bx && ay < by) begin
                    found = 1;
                    x0 = ax;
                    y0 = ay;
                    lo = i;
                end
            end
        end
        if (found) begin
            ovl_cnt++;
            probe(x0, y0, 1'b1);
            check("ovl_lowest_idx", int'(hit_b && (int'(idx_b) <= lo)), 1);
            probe(x0, y0, 1'b0);
            check("ovl_blank_hit", int'(hit_b), 0);
        end
    endtask

    // One accepted frame; optional extra tick mid-walk and enable drop
    task automatic run_frame(input int spd, input bit tick_mid, input bit en_drop);
        speed        = 2'(spd);
        enable       = 1'b1;
        video_active = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("a_busy", int'(busy_a), (k < 4) ? 1 : 0);
            check("a_done", int'(done_a), (k == 4) ? 1 : 0);
            check("b_busy", int'(busy_b), (k < 8) ? 1 : 0);
            check("b_done", int'(done_b), (k == 8) ? 1 : 0);
            if (k == 1) begin
                frame_tick = tick_mid;
                if (en_drop) enable = 1'b0;
            end else if (k == 4) begin
                frame_tick = tick_mid;
            end else begin
                frame_tick = 1'b0;
            end
            @(negedge clk);
        end
        enable = 1'b1;
        model_frame(0, spd);
        model_frame(1, spd);
    endtask

    task automatic disabled_tick();
        enable = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("dis_a_busy", int'(busy_a), 0);
            check("dis_a_done", int'(done_a), 0);
            check("dis_b_busy", int'(busy_b), 0);
            check("dis_b_done", int'(done_b), 0);
            @(negedge clk);
        end
        enable = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_tick   = 1'b0;
        enable       = 1'b0;
        speed        = 2'd0;
        video_active = 1'b0;
        pix_x        = '0;
        pix_y        = '0;
        model_reset(0);
        model_reset(1);

        repeat (3) @(negedge clk);
        check_en = 1;
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_hit", int'(hit_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset table pinned by hand
        probe(160, 232, 1'b1);
        check("lit_160_232_hit", int'(hit_a), 1);
        check("lit_160_232_idx", int'(idx_a), 3);
        probe(640, 40, 1'b1);
        check("lit_640_40_hit", int'(hit_a), 1);
        check("lit_640_40_idx", int'(idx_a), 0);
        probe(639, 40, 1'b1);
        check("lit_639_40_hit", int'(hit_a), 0);
        probe(160, 232, 1'b0);
        check("lit_blank_hit", int'(hit_a), 0);
        probe_all_a();

        // First frame at speed 2
        run_frame(2, 1'b0, 1'b0);
        probe(638, 42, 1'b1);
        check("lit_f1_s0_hit", int'(hit_a), 1);
        check("lit_f1_s0_idx", int'(idx_a), 0);
        probe(158, 234, 1'b1);
        check("lit_f1_s3_hit", int'(hit_a), 1);
        check("lit_f1_s3_idx", int'(idx_a), 3);
        probe(157, 234, 1'b1);
        check("lit_f1_s3_left", int'(hit_a), 0);
        probe(16, 393, 1'b1);
        check("lit_b7_respawn_hit", int'(hit_b), 1);
        check("lit_b7_respawn_idx", int'(idx_b), 7);
        probe_all_a();

        // Extra ticks while walking are dropped
        run_frame(1, 1'b1, 1'b0);
        probe_all_a();

        // Enable dropped mid-walk still completes the walk
        run_frame(3, 1'b0, 1'b1);
        probe_all_a();

        // Ticks while disabled leave the table alone
        disabled_tick();
        probe_all_a();

        for (int f = 0; f < 130; f++) begin
            int spd;
            spd = (f % 7 == 0) ? 0 : ((f % 5 == 0) ? 1 : 3);
            run_frame(spd, 1'b0, 1'b0);
            probe_all_a();
            probe_overlap_b();
        end

        // Reset during the second walk cycle
        speed  = 2'd3;
        enable = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check("midrst_a_busy", int'(busy_a), 0);
        check("midrst_b_busy", int'(busy_b), 0);
        check("midrst_a_done", int'(done_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        probe(160, 232, 1'b1);
        check("lit_midrst_hit", int'(hit_a), 1);
        check("lit_midrst_idx", int'(idx_a), 3);
        probe_all_a();

        run_frame(2, 1'b0, 1'b0);
        probe(16, 393, 1'b1);
        check("lit_midrst_b7_hit", int'(hit_b), 1);
        check("lit_midrst_b7_idx", int'(idx_b), 7);
        for (int f = 0; f < 20; f++) begin
            run_frame(f % 4, 1'b0, 1'b0);
            probe_all_a();
            probe_overlap_b();
        end

        check("wrap_row_seen", int'(wrap_cnt > 0), 1);
        check("overlap_seen", int'(ovl_cnt > 0), 1);

        check_en = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
